ysyx_23060096_imm_encoder: RTL and testbench

Inverse of the core's immediate generator: packs a 32-bit immediate into the scattered immediate fields of an RV32I instruction template for I/U/S/B/J formats. It also expands a load-immediate (LI) request into a LUI/ADDI pair. It sits between the debug/boot instruction injector and the fetch-side instruction buffer, emitting encoded words through a valid/ready stream with one registered output stage.

---
 rtl/ysyx_23060096_imm_encoder_if.sv | 24 ++
 rtl/ysyx_23060096_imm_encoder.sv | 145 ++++++++++++++
 tb/tb_ysyx_23060096_imm_encoder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060096_imm_encoder_if.sv
// Request/encoded-instruction stream bundle for the immediate encoder.
// master: instruction injector / downstream buffer side; slave: the encoder.
interface ysyx_23060096_imm_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_fmt;
    logic [31:0] req_base;
    logic [31:0] req_imm;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic        inst_last;
    logic        inst_err;

    modport master (
        output req_valid, req_fmt, req_base, req_imm, inst_ready,
        input  req_ready, inst_valid, inst, inst_last, inst_err
    );

    modport slave (
        input  req_valid, req_fmt, req_base, req_imm, inst_ready,
        output req_ready, inst_valid, inst, inst_last, inst_err
    );
endinterface

// File: rtl/ysyx_23060096_imm_encoder.sv
// Packs a 32-bit immediate into the immediate fields of an RV32I template
// (I/U/S/B/J) and expands LI into LUI/ADDI, behind one registered stage.
// Optional macro IMMENC_RANGE_CHECK_EN flags immediates that do not fit.
module ysyx_23060096_imm_encoder (
    input logic                         clk,
    input logic                         rstn,
    ysyx_23060096_imm_encoder_if.slave  bus
);

    localparam logic [31:0] MASK_I  = 32'hFFF0_0000;
    localparam logic [31:0] MASK_U  = 32'hFFFF_F000;
    localparam logic [31:0] MASK_SB = 32'hFE00_0F80;
    localparam logic [31:0] MASK_J  = 32'hFFFF_F000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_HOLD_LUI
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic [31:0] addi_q, addi_d;

    logic [31:0] enc_word;
    logic        enc_last;
    logic        enc_err;
    logic        enc_two;
    logic [31:0] enc_addi;
    logic [31:0] imm_plus;
    logic [19:0] li_hi;
    logic [11:0] li_lo;
    logic [4:0]  li_rd;
    logic        accept;

    assign bus.inst_valid = (state_q != ST_IDLE);
    assign bus.inst       = inst_q;
    assign bus.inst_last  = last_q;
    assign bus.inst_err   = err_q;
    assign bus.req_ready  = rstn &&
                            ((state_q == ST_IDLE) ||
                             ((state_q == ST_HOLD) && bus.inst_ready));
    assign accept         = bus.req_valid && bus.req_ready;

    // Combinational encode of the live request into first word / pending ADDI.
    always_comb begin
        enc_word = bus.req_base;
        enc_last = 1'b1;
        enc_err  = 1'b0;
        enc_two  = 1'b0;
        enc_addi = '0;
        imm_plus = bus.req_imm + 32'h0000_0800;
        li_hi    = imm_plus[31:12];
        li_lo    = bus.req_imm[11:0];
        li_rd    = bus.req_base[11:7];
        case (bus.req_fmt)
            3'd0: enc_word = (bus.req_base & ~MASK_I) | {bus.req_imm[11:0], 20'b0};
            3'd1: enc_word = (bus.req_base & ~MASK_U) | {bus.req_imm[31:12], 12'b0};
            3'd2: enc_word = (bus.req_base & ~MASK_SB) |
                             {bus.req_imm[11:5], 13'b0, bus.req_imm[4:0], 7'b0};
            3'd3: enc_word = (bus.req_base & ~MASK_SB) |
                             {bus.req_imm[12], bus.req_imm[10:5], 13'b0,
                              bus.req_imm[4:1], bus.req_imm[11], 7'b0};
            3'd4: enc_word = (bus.req_base & ~MASK_J) |
                             {bus.req_imm[20], bus.req_imm[10:1], bus.req_imm[11],
                              bus.req_imm[19:12], 12'b0};
            3'd5: begin
                if (li_hi == 20'd0) begin
                    enc_word = {li_lo, 5'd0, 3'b000, li_rd, 7'h13};
                end else begin
                    enc_word = {li_hi, li_rd, 7'h37};
                    if (li_lo != 12'd0) begin
                        enc_last = 1'b0;
                        enc_two  = 1'b1;
                        enc_addi = {li_lo, li_rd, 3'b000, li_rd, 7'h13};
                    end
                end
            end
            default: enc_err = 1'b1;
        endcase
`ifdef IMMENC_RANGE_CHECK_EN
        case (bus.req_fmt)
            3'd0, 3'd2: if (($signed(bus.req_imm) < -32'sd2048) ||
                            ($signed(bus.req_imm) > 32'sd2047)) enc_err = 1'b1;
            3'd1: if (bus.req_imm[11:0] != 12'd0) enc_err = 1'b1;
            3'd3: if (bus.req_imm[0] || ($signed(bus.req_imm) < -32'sd4096) ||
                      ($signed(bus.req_imm) > 32'sd4094)) enc_err = 1'b1;
            3'd4: if (bus.req_imm[0] || ($signed(bus.req_imm) < -32'sd1048576) ||
                      ($signed(bus.req_imm) > 32'sd1048574)) enc_err = 1'b1;
            default: ;
        endcase
`endif
    end

    // Next-state and output-register update for the IDLE/HOLD/HOLD_LUI machine.
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        last_d  = last_q;
        err_d   = err_q;
        addi_d  = addi_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    inst_d  = enc_word;
                    last_d  = enc_last;
                    err_d   = enc_err;
                    addi_d  = enc_addi;
                    state_d = enc_two ? ST_HOLD_LUI : ST_HOLD;
                end else if ((state_q == ST_HOLD) && bus.inst_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD_LUI: begin
                if (bus.inst_ready) begin
                    inst_d  = addi_q;
                    last_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            inst_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            addi_q  <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            last_q  <= last_d;
            err_q   <= err_d;
            addi_q  <= addi_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_imm_encoder.sv
// Directed bench for ysyx_23060096_imm_encoder (both IMMENC_RANGE_CHECK_EN builds).
module tb_ysyx_23060096_imm_encoder;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_errors;

    ysyx_23060096_imm_encoder_if bus();

    ysyx_23060096_imm_encoder dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [31:0] base;
        logic [31:0] imm;
        logic [31:0] inst;
        logic        err_n;
        logic        err_m;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [31:0] base, input logic [31:0] imm);
        bus.req_valid = 1'b1;
        bus.req_fmt   = fmt;
        bus.req_base  = base;
        bus.req_imm   = imm;
    endtask

    task automatic chk_out(input string name, input logic [31:0] w, input logic l, input logic e);
        chk({name, ".valid"}, {31'b0, bus.inst_valid}, 32'd1);
        chk({name, ".inst"},  bus.inst, w);
        chk({name, ".last"},  {31'b0, bus.inst_last}, {31'b0, l});
        chk({name, ".err"},   {31'b0, bus.inst_err}, {31'b0, e});
    endtask

    initial begin
        logic exp_err;
        logic [31:0] held;
        n_checks = 0;
        n_errors = 0;

        vq.push_back(vec_t'{3'd0, 32'h0000_0013, 32'h0000_0800, 32'h8000_0013, 1'b0, 1'b1});
        vq.push_back(vec_t'{3'd0, 32'h0000_0093, 32'h0000_07FF, 32'h7FF0_0093, 1'b0, 1'b0});
        vq.push_back(vec_t'{3'd0, 32'h0000_0013, 32'hFFFF_F800, 32'h8000_0013, 1'b0, 1'b0});
        vq.push_back(vec_t'{3'd0, 32'hFFF0_0013, 32'h0000_0001, 32'h0010_0013, 1'b0, 1'b0});
        vq.push_back(vec_t'{3'd1, 32'h0000_00B7, 32'h1234_5000, 32'h1234_50B7, 1'b0, 1'b0});
        vq.push_back(vec_t'{3'd1, 32'h0000_00B7, 32'h1234_5678, 32'h1234_50B7, 1'b0, 1'b1});
        vq.push_back(vec_t'{3'd2, 32'h0000_0023, 32'hFFFF_FFFF, 32'hFE00_0FA3, 1'b0, 1'b0});
        vq.push_back(vec_t'{3'd2, 32'h0000_0023, 32'h0000_07FF, 32'h7E00_0FA3, 1'b0, 1'b0});
        vq.push_back(vec_t'{3'd3, 32'h0000_0063, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, 1'b0});
        vq.push_back(vec_t'{3'd3, 32'h0000_0063, 32'h0000_0FFE, 32'h7E00_0FE3, 1'b0, 1'b0});
        vq.push_back(vec_t'{3'd3, 32'h0000_0063, 32'h0000_0003, 32'h0000_0163, 1'b0, 1'b1});
        vq.push_back(vec_t'{3'd4, 32'h0000_006F, 32'h0000_0800, 32'h0010_006F, 1'b0, 1'b0});
        vq.push_back(vec_t'{3'd4, 32'h0000_00EF, 32'hFFFF_FFFE, 32'hFFFF_F0EF, 1'b0, 1'b0});
        vq.push_back(vec_t'{3'd4, 32'h0000_006F, 32'h0010_0000, 32'h8000_006F, 1'b0, 1'b1});
        vq.push_back(vec_t'{3'd6, 32'hDEAD_BEEF, 32'h0000_0005, 32'hDEAD_BEEF, 1'b1, 1'b1});
        vq.push_back(vec_t'{3'd7, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b1, 1'b1});
        vq.push_back(vec_t'{3'd5, 32'h0000_0080, 32'h0000_1000, 32'h0000_10B7, 1'b0, 1'b0});
        vq.push_back(vec_t'{3'd5, 32'h0000_0080, 32'h0000_07FF, 32'h7FF0_0093, 1'b0, 1'b0});
        vq.push_back(vec_t'{3'd5, 32'h0000_0100, 32'h0000_0000, 32'h0000_0113, 1'b0, 1'b0});
        vq.push_back(vec_t'{3'd5, 32'h0000_0080, 32'hFFFF_F800, 32'h8000_0093, 1'b0, 1'b0});

        // Reset state
        rstn = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_fmt = 3'd0;
        bus.req_base = '0;
        bus.req_imm = '0;
        bus.inst_ready = 1'b0;
        repeat (3) step();
        chk("rst.valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("rst.inst", bus.inst, 32'd0);
        chk("rst.last", {31'b0, bus.inst_last}, 32'd0);
        chk("rst.err", {31'b0, bus.inst_err}, 32'd0);
        chk("rst.req_ready", {31'b0, bus.req_ready}, 32'd0);

        // Back-to-back single-word table
        rstn = 1'b1;
        bus.inst_ready = 1'b1;
        #1;
        for (int i = 0; i < vq.size(); i++) begin
`ifdef IMMENC_RANGE_CHECK_EN
            exp_err = vq[i].err_m;
`else
            exp_err = vq[i].err_n;
`endif
            drive(vq[i].fmt, vq[i].base, vq[i].imm);
            #1;
            chk($sformatf("v%0d.req_ready", i), {31'b0, bus.req_ready}, 32'd1);
            step();
            chk_out($sformatf("v%0d", i), vq[i].inst, 1'b1, exp_err);
        end
        bus.req_valid = 1'b0;
        step();
        chk("drain.valid", {31'b0, bus.inst_valid}, 32'd0);

        // Two-word LI; ADDI must come from captured fields
        drive(3'd5, 32'h0000_0280, 32'h1234_5FFF);
        step();
        chk_out("li2.lui", 32'h1234_62B7, 1'b0, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_fmt   = 3'd5;
        bus.req_base  = 32'hFFFF_FFFF;
        bus.req_imm   = 32'h0000_0001;
        #1;
        chk("li2.req_ready", {31'b0, bus.req_ready}, 32'd0);
        bus.req_valid = 1'b0;
        step();
        chk_out("li2.addi", 32'hFFF2_8293, 1'b1, 1'b0);
        step();
        chk("li2.idle", {31'b0, bus.inst_valid}, 32'd0);

        // S encode under back-pressure
        bus.inst_ready = 1'b0;
        drive(3'd2, 32'h0000_0023, 32'hFFFF_FFFF);
        step();
        drive(3'd0, 32'h0000_0013, 32'h0000_0001);
        for (int k = 0; k < 3; k++) begin
            chk_out($sformatf("stall%0d", k), 32'hFE00_0FA3, 1'b1, 1'b0);
            chk($sformatf("stall%0d.req_ready", k), {31'b0, bus.req_ready}, 32'd0);
            step();
        end
        bus.req_valid = 1'b0;
        held = bus.inst;
        chk("stall.held", held, 32'hFE00_0FA3);
        bus.inst_ready = 1'b1;
        step();
        chk("stall.release", {31'b0, bus.inst_valid}, 32'd0);

        // Reset while LUI held with ADDI pending
        bus.inst_ready = 1'b0;
        drive(3'd5, 32'h0000_0280, 32'h1234_5FFF);
        step();
        bus.req_valid = 1'b0;
        chk_out("rlui.lui", 32'h1234_62B7, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        chk("rlui.req_ready", {31'b0, bus.req_ready}, 32'd0);
        step();
        chk("rlui.valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("rlui.inst", bus.inst, 32'd0);
        rstn = 1'b1;
        bus.inst_ready = 1'b1;
        drive(3'd0, 32'h0000_0013, 32'h0000_0005);
        step();
        bus.req_valid = 1'b0;
        chk_out("post_rst", 32'h0050_0013, 1'b1, 1'b0);
        step();
        chk("post_rst.idle", {31'b0, bus.inst_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
